// File: rtl/lfsr_rand_arbiter_pkg.sv
// lfsr_rand_pkg: shared LFSR constants, FSM state type and the LFSR step function
package lfsr_rand_pkg;
  localparam int LFSR_LEN = 128;
  localparam int TAPS [6] = '{127, 51, 13, 8, 4, 1};
  typedef enum logic [1:0] {WARMUP, READY, REFRESH} lfsr_state_e;
  function automatic logic [LFSR_LEN-1:0] lfsr_step(input logic [LFSR_LEN-1:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 6; i++) fb ^= s[TAPS[i]];
    return {s[LFSR_LEN-2:0], ~fb};
  endfunction
endpackage

// File: rtl/lfsr_rand_arbiter_if.sv
// lfsr_rand_arbiter_if: reseed, request/grant and random-word signals of the shared LFSR arbiter
interface lfsr_rand_arbiter_if
  import lfsr_rand_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  logic                seed_valid_i;
  logic [LFSR_LEN-1:0] seed_i;
  logic                seed_ready_o;
  logic [NUM_REQ-1:0]  req_i;
  logic [NUM_REQ-1:0]  gnt_o;
  logic [WIDTH-1:0]    rand_o;
  logic                busy_o;
  modport master (output seed_valid_i, seed_i, req_i, input seed_ready_o, gnt_o, rand_o, busy_o);
  modport slave  (input seed_valid_i, seed_i, req_i, output seed_ready_o, gnt_o, rand_o, busy_o);
endinterface

// File: rtl/lfsr_rand_arbiter_rr_arb.sv
// rr_arb_onehot: combinational round-robin pick of the first request at or above ptr, with wrap
module rr_arb_onehot #(
  parameter int NUM_REQ = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] cand;
  // walk offsets from farthest to nearest so the nearest request wins
  always_comb begin
    idx = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) idx = cand;
    end
  end
  assign gnt = (en && |req) ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: one 128-bit LFSR shared round-robin among NUM_REQ requesters with warm-up/refresh/reseed.
// Define LFSR_RAND_ARB_FREE_RUN_EN to let the LFSR step on idle READY cycles.
module lfsr_rand_arbiter
  import lfsr_rand_pkg::*;
#(
  parameter int                  NUM_REQ       = 4,
  parameter int                  WIDTH         = 8,
  parameter logic [LFSR_LEN-1:0] DEFAULT_SEED  = 128'h1,
  parameter int                  WARMUP_STEPS  = 4,
  parameter int                  REFRESH_STEPS = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  lfsr_rand_arbiter_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [LFSR_LEN-1:0] s_q, s_d;
  lfsr_state_e         state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d, idx;
  logic [NUM_REQ-1:0]  gnt;
  logic                arb_en;
  assign arb_en = state_q == READY && !bus.seed_valid_i;
  rr_arb_onehot #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(bus.req_i),
    .ptr(ptr_q),
    .en (arb_en),
    .gnt(gnt),
    .idx(idx)
  );
  assign bus.gnt_o        = gnt;
  assign bus.rand_o       = s_q[WIDTH-1:0];
  assign bus.busy_o       = state_q != READY;
  assign bus.seed_ready_o = state_q == READY;
  always_comb begin
    s_d = s_q;
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (state_q == WARMUP) begin
      if (cnt_q != 8'd0) begin
        s_d = lfsr_step(s_q);
        cnt_d = cnt_q - 8'd1;
      end else state_d = READY;
    end else if (state_q == REFRESH) begin
      s_d = lfsr_step(s_q);
      cnt_d = cnt_q - 8'd1;
      state_d = cnt_q == 8'd1 ? READY : REFRESH;
    end else if (bus.seed_valid_i) begin
      // an all-ones seed would lock the LFSR, so fall back to the reset seed
      s_d = &bus.seed_i ? DEFAULT_SEED : bus.seed_i;
      cnt_d = 8'(WARMUP_STEPS);
      state_d = WARMUP;
    end else if (|gnt) begin
      s_d = lfsr_step(s_q);
      ptr_d = idx == IW'(NUM_REQ - 1) ? '0 : idx + IW'(1);
      cnt_d = 8'(REFRESH_STEPS);
      state_d = REFRESH_STEPS != 0 ? REFRESH : READY;
    end
`ifdef LFSR_RAND_ARB_FREE_RUN_EN
    else s_d = lfsr_step(s_q);
`endif
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q <= DEFAULT_SEED;
      state_q <= WARMUP;
      cnt_q <= 8'(WARMUP_STEPS);
      ptr_q <= '0;
    end else begin
      s_q <= s_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end
endmodule
